lamp_fpu_opq: RTL and testbench
===============================

LAMP_FPU_OPQ -- requirements
Module: lamp_fpu_opq

Interface
- REQ-001 SHALL have parameters: DEPTH (4), queue entries, power of 2, >=2; TAG_W (4), request tag width; INT_DW (32), integer/result width; FLOAT_DW (16), bfloat16 operand width; TIMEOUT_CYC (64), watchdog limit in cycles (REQ-024).
- REQ-002 SHALL have ports (opcode and round-mode types from lampFPU_pkg):
  - clk  in  1  clock; all state on rising edge
  - rst_n  in  1  asynchronous, active-low reset
  - flush_i  in  1  synchronous flush
  - req_valid_i  in  1  request valid
  - req_ready_o  out  1  queue can accept
  - req_opcode_i  in  opcodeFPU_t  operation
  - req_rndMode_i  in  rndModeFPU_t  rounding mode
  - req_op1_i  in  INT_DW  operand 1
  - req_op2_i  in  FLOAT_DW  operand 2
  - req_tag_i  in  TAG_W  request tag
  - rsp_valid_o  out  1  response valid
  - rsp_ready_i  in  1  response consumed
  - rsp_result_o  out  INT_DW  FPU result
  - rsp_tag_o  out  TAG_W  tag of completed request
  - rsp_timeout_o  out  1  response was produced by the watchdog
  - count_o  out  $clog2(DEPTH)+1  queue occupancy
  - fpu_opcode_o  out  opcodeFPU_t  to core opcode_i
  - fpu_rndMode_o  out  rndModeFPU_t  to core rndMode_i
  - fpu_op1_o  out  INT_DW  to core op1_i
  - fpu_op2_o  out  FLOAT_DW  to core op2_i
  - fpu_flush_o  out  1  to core flush_i
  - fpu_padv_o  out  1  to core padv_i; constant 1
  - fpu_result_i  in  INT_DW  from core result_o
  - fpu_isResultValid_i  in  1  from core isResultValid_o
  - fpu_isReady_i  in  1  from core isReady_o

Function
- REQ-003 Queue SHALL be an in-order FIFO of DEPTH entries {opcode, rndMode, op1, op2, tag}.
- REQ-004 A request SHALL be pushed on a cycle when req_valid_i && req_ready_o, where req_ready_o = !full && !flush_i; there SHALL be no bypass path around the queue.
- REQ-005 Pointers SHALL wrap modulo DEPTH; count_o SHALL equal the number of stored entries, 0..DEPTH.
- REQ-006 FSM states SHALL be IDLE, ISSUE and WAIT.
- REQ-007 IDLE->ISSUE SHALL occur when count_o!=0 && fpu_isReady_i && !rsp_valid_o; otherwise the FSM SHALL stay in IDLE.
- REQ-008 In ISSUE, for exactly one cycle, fpu_opcode_o/rndMode/op1/op2 SHALL present the head entry; the head SHALL pop at the end of that cycle, and the FSM SHALL go to WAIT.
- REQ-009 Outside ISSUE, fpu_opcode_o SHALL be FPU_IDLE; fpu_op1_o, fpu_op2_o and fpu_rndMode_o SHALL hold their last-issued values.
- REQ-010 The tag of the issued entry SHALL be held in an in-flight register.
- REQ-011 In WAIT, on fpu_isResultValid_i, the FSM SHALL capture fpu_result_i and the in-flight tag into the response register, set rsp_valid_o on the next cycle, and go to IDLE.
- REQ-012 rsp_valid_o, rsp_result_o, rsp_tag_o and rsp_timeout_o SHALL stay stable until rsp_valid_o && rsp_ready_i, then clear on the next cycle.
- REQ-013 At most one operation SHALL be outstanding; responses SHALL return in request order.
- REQ-014 Minimum latency: request accepted in cycle t into an empty queue with the FSM in IDLE SHALL produce ISSUE in cycle t+2.
- REQ-015 A push and a pop in the same cycle SHALL leave count_o unchanged.
- REQ-016 fpu_isResultValid_i outside WAIT SHALL be ignored.
- REQ-017 flush_i SHALL empty the queue, clear rsp_valid_o and the in-flight tag, and force IDLE on the next cycle.
- REQ-018 fpu_flush_o SHALL equal flush_i combinationally.
- REQ-019 A request presented in a flush cycle SHALL NOT be accepted.

Reset
- REQ-020 rst_n low SHALL asynchronously clear pointers, count_o, the response register, rsp_valid_o, rsp_timeout_o and the in-flight tag, and SHALL set state=IDLE and fpu_opcode_o=FPU_IDLE.
- REQ-021 After reset, fpu_op1_o and fpu_op2_o SHALL be 0, fpu_rndMode_o SHALL be FPU_RNDMODE_NEAREST, fpu_flush_o SHALL be 0, fpu_padv_o SHALL be 1, and req_ready_o SHALL be 1.
- REQ-022 Reset asserted mid-operation SHALL discard all queued and in-flight work with no response.

Configuration
- REQ-023 The macro LAMP_FPU_OPQ_TIMEOUT_EN SHALL select whether the WAIT-state watchdog is compiled in.
- REQ-024 With the macro defined, a counter SHALL count cycles spent in WAIT. On reaching TIMEOUT_CYC without fpu_isResultValid_i, the block SHALL:
  - assert fpu_flush_o for one cycle;
  - load rsp_result_o='0, the in-flight tag and rsp_timeout_o=1;
  - go to IDLE.
- REQ-025 With the macro undefined, WAIT SHALL wait indefinitely, rsp_timeout_o SHALL be tied 0, and no counter SHALL be present.

Verification
- REQ-026 Single op: FPU_ADD op1=0x3F80, op2=0x4000, tag 3 with a lampFPU core -> exactly one ISSUE cycle, then rsp_result_o=0x4040, rsp_tag_o=3.
- REQ-027 Fill: DEPTH+1 back-to-back requests with the core held not-ready -> count_o=DEPTH, req_ready_o=0, last request not accepted; on release, responses return in tag order 0..DEPTH-1.
- REQ-028 Backpressure: rsp_ready_i=0 for 10 cycles with 2 queued ops -> response held stable, no second ISSUE until consumed.
- REQ-029 Flush in WAIT with 3 queued -> fpu_flush_o=1 that cycle, count_o=0 and IDLE next cycle, no response.
- REQ-030 Async reset asserted in ISSUE -> all outputs at reset values immediately.
- REQ-031 With LAMP_FPU_OPQ_TIMEOUT_EN and TIMEOUT_CYC=8, core never returns valid -> at WAIT cycle 8: fpu_flush_o pulse, response with rsp_timeout_o=1, result 0, correct tag.

Source files
------------

// File: rtl/lamp_fpu_opq.sv
// Operation queue in front of a lampFPU core: in-order FIFO, single-outstanding issue FSM, response register.
// Optional WAIT-state watchdog compiled in with `define LAMP_FPU_OPQ_TIMEOUT_EN.

package lampFPU_pkg;

   typedef enum logic [3:0] {
      FPU_IDLE = 4'd0,
      FPU_ADD  = 4'd1,
      FPU_SUB  = 4'd2,
      FPU_MUL  = 4'd3,
      FPU_DIV  = 4'd4,
      FPU_I2F  = 4'd5,
      FPU_F2I  = 4'd6,
      FPU_EQ   = 4'd7,
      FPU_LT   = 4'd8,
      FPU_LE   = 4'd9
   } opcodeFPU_t;

   typedef enum logic [2:0] {
      FPU_RNDMODE_NEAREST   = 3'd0,
      FPU_RNDMODE_TRUNCATE  = 3'd1,
      FPU_RNDMODE_PLUS_INF  = 3'd2,
      FPU_RNDMODE_MINUS_INF = 3'd3
   } rndModeFPU_t;

endpackage

module lamp_fpu_opq
   import lampFPU_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned INT_DW      = 32,
   parameter int unsigned FLOAT_DW    = 16,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  opcodeFPU_t                req_opcode_i,
   input  rndModeFPU_t               req_rndMode_i,
   input  logic [INT_DW-1:0]         req_op1_i,
   input  logic [FLOAT_DW-1:0]       req_op2_i,
   input  logic [TAG_W-1:0]          req_tag_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [INT_DW-1:0]         rsp_result_o,
   output logic [TAG_W-1:0]          rsp_tag_o,
   output logic                      rsp_timeout_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output opcodeFPU_t                fpu_opcode_o,
   output rndModeFPU_t               fpu_rndMode_o,
   output logic [INT_DW-1:0]         fpu_op1_o,
   output logic [FLOAT_DW-1:0]       fpu_op2_o,
   output logic                      fpu_flush_o,
   output logic                      fpu_padv_o,
   input  logic [INT_DW-1:0]         fpu_result_i,
   input  logic                      fpu_isResultValid_i,
   input  logic                      fpu_isReady_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_config
      $error("lamp_fpu_opq: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef struct packed {
      opcodeFPU_t          opcode;
      rndModeFPU_t         rnd_mode;
      logic [INT_DW-1:0]   op1;
      logic [FLOAT_DW-1:0] op2;
      logic [TAG_W-1:0]    tag;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   entry_t              mem_q [DEPTH];
   entry_t              head;

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   state_t              state_q, state_d;
   logic [TAG_W-1:0]    inflight_tag_q, inflight_tag_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [INT_DW-1:0]   rsp_result_q, rsp_result_d;
   logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
   rndModeFPU_t         last_rnd_q, last_rnd_d;
   logic [INT_DW-1:0]   last_op1_q, last_op1_d;
   logic [FLOAT_DW-1:0] last_op2_q, last_op2_d;

   logic                full;
   logic                push;
   logic                pop;
   logic                timeout_hit;

   assign head        = mem_q[rd_ptr_q];
   assign full        = (count_q == CNT_W'(DEPTH));
   assign req_ready_o = !full && !flush_i;
   assign push        = req_valid_i && req_ready_o;
   assign pop         = (state_q == ISSUE);

   // Storage is written only on an accepted push; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{opcode:   req_opcode_i,
                              rnd_mode: req_rndMode_i,
                              op1:      req_op1_i,
                              op2:      req_op2_i,
                              tag:      req_tag_i};
      end
   end

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      state_d        = state_q;
      inflight_tag_d = inflight_tag_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_result_d   = rsp_result_q;
      rsp_tag_d      = rsp_tag_q;
      last_rnd_d     = last_rnd_q;
      last_op1_d     = last_op1_q;
      last_op2_d     = last_op2_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d  = 1'b0;
         rsp_result_d = '0;
         rsp_tag_d    = '0;
      end

      case (state_q)
         IDLE: begin
            if (count_q != '0 && fpu_isReady_i && !rsp_valid_q) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d        = WAIT;
            inflight_tag_d = head.tag;
            last_rnd_d     = head.rnd_mode;
            last_op1_d     = head.op1;
            last_op2_d     = head.op2;
         end
         WAIT: begin
            if (fpu_isResultValid_i) begin
               state_d      = IDLE;
               rsp_valid_d  = 1'b1;
               rsp_result_d = fpu_result_i;
               rsp_tag_d    = inflight_tag_q;
            end else if (timeout_hit) begin
               state_d      = IDLE;
               rsp_valid_d  = 1'b1;
               rsp_result_d = '0;
               rsp_tag_d    = inflight_tag_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush wins over everything: the queue empties and any in-flight result is dropped.
      if (flush_i) begin
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         count_d        = '0;
         state_d        = IDLE;
         inflight_tag_d = '0;
         rsp_valid_d    = 1'b0;
         rsp_result_d   = '0;
         rsp_tag_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         state_q        <= IDLE;
         inflight_tag_q <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_result_q   <= '0;
         rsp_tag_q      <= '0;
         last_rnd_q     <= FPU_RNDMODE_NEAREST;
         last_op1_q     <= '0;
         last_op2_q     <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         state_q        <= state_d;
         inflight_tag_q <= inflight_tag_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_result_q   <= rsp_result_d;
         rsp_tag_q      <= rsp_tag_d;
         last_rnd_q     <= last_rnd_d;
         last_op1_q     <= last_op1_d;
         last_op2_q     <= last_op2_d;
      end
   end

`ifdef LAMP_FPU_OPQ_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            rsp_timeout_q, rsp_timeout_d;

   // The counter holds the number of completed WAIT cycles, so it fires in WAIT cycle TIMEOUT_CYC.
   assign timeout_hit = (state_q == WAIT) && !fpu_isResultValid_i &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

   always_comb begin
      wd_cnt_d      = wd_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
      if (flush_i || state_q != WAIT) begin
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
      if (rsp_valid_q && rsp_ready_i) begin
         rsp_timeout_d = 1'b0;
      end
      if (state_q == WAIT && fpu_isResultValid_i) begin
         rsp_timeout_d = 1'b0;
      end else if (timeout_hit) begin
         rsp_timeout_d = 1'b1;
      end
      if (flush_i) begin
         rsp_timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q      <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_timeout_o = rsp_timeout_q;
`else
   assign timeout_hit   = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   // The head entry is visible to the core only during the single ISSUE cycle.
   assign fpu_opcode_o  = (state_q == ISSUE) ? head.opcode   : FPU_IDLE;
   assign fpu_rndMode_o = (state_q == ISSUE) ? head.rnd_mode : last_rnd_q;
   assign fpu_op1_o     = (state_q == ISSUE) ? head.op1      : last_op1_q;
   assign fpu_op2_o     = (state_q == ISSUE) ? head.op2      : last_op2_q;
   assign fpu_flush_o   = flush_i || timeout_hit;
   assign fpu_padv_o    = 1'b1;

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_result_o  = rsp_result_q;
   assign rsp_tag_o     = rsp_tag_q;
   assign count_o       = count_q;

endmodule

// File: tb/tb_lamp_fpu_opq.sv
// Self-checking bench for lamp_fpu_opq with a behavioural FPU core model (fixed latency, optional hang).

module tb_lamp_fpu_opq;
   import lampFPU_pkg::*;

   localparam int DEPTH       = 4;
   localparam int TAG_W       = 4;
   localparam int INT_DW      = 32;
   localparam int FLOAT_DW    = 16;
   localparam int TIMEOUT_CYC = 8;
   localparam int CORE_LAT    = 3;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   flush_i = 1'b0;
   logic                   req_valid_i = 1'b0;
   logic                   req_ready_o;
   opcodeFPU_t             req_opcode_i = FPU_IDLE;
   rndModeFPU_t            req_rndMode_i = FPU_RNDMODE_NEAREST;
   logic [INT_DW-1:0]      req_op1_i = '0;
   logic [FLOAT_DW-1:0]    req_op2_i = '0;
   logic [TAG_W-1:0]       req_tag_i = '0;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i = 1'b1;
   logic [INT_DW-1:0]      rsp_result_o;
   logic [TAG_W-1:0]       rsp_tag_o;
   logic                   rsp_timeout_o;
   logic [$clog2(DEPTH):0] count_o;
   opcodeFPU_t             fpu_opcode_o;
   rndModeFPU_t            fpu_rndMode_o;
   logic [INT_DW-1:0]      fpu_op1_o;
   logic [FLOAT_DW-1:0]    fpu_op2_o;
   logic                   fpu_flush_o;
   logic                   fpu_padv_o;
   logic [INT_DW-1:0]      fpu_result_i;
   logic                   fpu_isResultValid_i;
   logic                   fpu_isReady_i;

   logic                   core_ready = 1'b1;
   logic                   core_hang = 1'b0;
   logic                   spur_valid = 1'b0;
   logic                   core_busy;
   int                     core_cnt;
   logic [INT_DW-1:0]      core_pend;
   logic                   core_valid;
   logic [INT_DW-1:0]      core_result;

   int                     n_cmp = 0;
   int                     n_bad = 0;
   int                     issue_cnt = 0;
   logic [TAG_W-1:0]       got_tag [$];
   logic [INT_DW-1:0]      got_res [$];
   logic                   got_to  [$];

   typedef struct {
      opcodeFPU_t          op;
      rndModeFPU_t         rm;
      logic [INT_DW-1:0]   op1;
      logic [FLOAT_DW-1:0] op2;
      logic [TAG_W-1:0]    tag;
      logic [INT_DW-1:0]   exp_res;
   } vec_t;

   vec_t vec [4];

   lamp_fpu_opq #(
      .DEPTH       (DEPTH),
      .TAG_W       (TAG_W),
      .INT_DW      (INT_DW),
      .FLOAT_DW    (FLOAT_DW),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .flush_i             (flush_i),
      .req_valid_i         (req_valid_i),
      .req_ready_o         (req_ready_o),
      .req_opcode_i        (req_opcode_i),
      .req_rndMode_i       (req_rndMode_i),
      .req_op1_i           (req_op1_i),
      .req_op2_i           (req_op2_i),
      .req_tag_i           (req_tag_i),
      .rsp_valid_o         (rsp_valid_o),
      .rsp_ready_i         (rsp_ready_i),
      .rsp_result_o        (rsp_result_o),
      .rsp_tag_o           (rsp_tag_o),
      .rsp_timeout_o       (rsp_timeout_o),
      .count_o             (count_o),
      .fpu_opcode_o        (fpu_opcode_o),
      .fpu_rndMode_o       (fpu_rndMode_o),
      .fpu_op1_o           (fpu_op1_o),
      .fpu_op2_o           (fpu_op2_o),
      .fpu_flush_o         (fpu_flush_o),
      .fpu_padv_o          (fpu_padv_o),
      .fpu_result_i        (fpu_result_i),
      .fpu_isResultValid_i (fpu_isResultValid_i),
      .fpu_isReady_i       (fpu_isReady_i)
   );

   always #5 clk = ~clk;

   assign fpu_isReady_i       = core_ready;
   assign fpu_isResultValid_i = core_valid | spur_valid;
   assign fpu_result_i        = core_result;

   // Core stand-in: known bfloat16 add case, otherwise an integer sum so every vector has a distinct answer.
   function automatic logic [INT_DW-1:0] coreCompute(input opcodeFPU_t op, input logic [INT_DW-1:0] a,
                                                     input logic [FLOAT_DW-1:0] b);
      if (op == FPU_ADD && a == 32'h0000_3F80 && b == 16'h4000) return 32'h0000_4040;
      return a + {16'h0000, b};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_busy   <= 1'b0;
         core_cnt    <= 0;
         core_pend   <= '0;
         core_valid  <= 1'b0;
         core_result <= '0;
      end else begin
         core_valid <= 1'b0;
         if (fpu_flush_o) begin
            core_busy <= 1'b0;
         end else if (fpu_opcode_o != FPU_IDLE) begin
            core_busy <= 1'b1;
            core_cnt  <= CORE_LAT;
            core_pend <= coreCompute(fpu_opcode_o, fpu_op1_o, fpu_op2_o);
         end else if (core_busy && !core_hang) begin
            if (core_cnt == 1) begin
               core_valid  <= 1'b1;
               core_result <= core_pend;
               core_busy   <= 1'b0;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
      end
   end

   // Monitors: ISSUE cycles seen by the core, and responses handed to the consumer.
   always @(posedge clk) begin
      if (rst_n && fpu_opcode_o != FPU_IDLE) issue_cnt++;
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
         got_tag.push_back(rsp_tag_o);
         got_res.push_back(rsp_result_o);
         got_to.push_back(rsp_timeout_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input opcodeFPU_t op, input rndModeFPU_t rm, input logic [INT_DW-1:0] a,
                                input logic [FLOAT_DW-1:0] b, input logic [TAG_W-1:0] tag);
      req_valid_i   = 1'b1;
      req_opcode_i  = op;
      req_rndMode_i = rm;
      req_op1_i     = a;
      req_op2_i     = b;
      req_tag_i     = tag;
      tick();
      req_valid_i   = 1'b0;
   endtask

   task automatic waitRsp(input int target, input string name);
      for (int k = 0; k < 300 && got_tag.size() < target; k++) tick();
      checkOutput(name, 32'(got_tag.size() >= target), 32'd1);
   endtask

   task automatic doReset();
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      core_ready  = 1'b1;
      core_hang   = 1'b0;
      spur_valid  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int base_rsp;
      int base_iss;

      vec[0] = '{FPU_ADD, FPU_RNDMODE_NEAREST,   32'h0000_3F80, 16'h4000, 4'd3,  32'h0000_4040};
      vec[1] = '{FPU_SUB, FPU_RNDMODE_TRUNCATE,  32'h0000_0100, 16'h0023, 4'd5,  32'h0000_0123};
      vec[2] = '{FPU_MUL, FPU_RNDMODE_PLUS_INF,  32'hFFFF_FFFF, 16'h0001, 4'hF,  32'h0000_0000};
      vec[3] = '{FPU_DIV, FPU_RNDMODE_MINUS_INF, 32'h1234_0000, 16'hABCD, 4'd0,  32'h1234_ABCD};

      doReset();
      $display("[TB] reset values");
      checkOutput("rst_count", 32'(count_o), 32'd0);
      checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_timeout", 32'(rsp_timeout_o), 32'd0);
      checkOutput("rst_opcode", 32'(fpu_opcode_o), 32'(FPU_IDLE));
      checkOutput("rst_op1", fpu_op1_o, 32'd0);
      checkOutput("rst_op2", 32'(fpu_op2_o), 32'd0);
      checkOutput("rst_rnd", 32'(fpu_rndMode_o), 32'(FPU_RNDMODE_NEAREST));
      checkOutput("rst_flush", 32'(fpu_flush_o), 32'd0);
      checkOutput("rst_padv", 32'(fpu_padv_o), 32'd1);

      $display("[TB] stray result valid while idle");
      spur_valid = 1'b1;
      tick();
      spur_valid = 1'b0;
      tick();
      checkOutput("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);

      $display("[TB] single-op vectors");
      for (int i = 0; i < 4; i++) begin
         base_rsp = got_tag.size();
         base_iss = issue_cnt;
         applyStimulus(vec[i].op, vec[i].rm, vec[i].op1, vec[i].op2, vec[i].tag);
         checkOutput("lat_t1_idle", 32'(fpu_opcode_o), 32'(FPU_IDLE));
         checkOutput("lat_t1_count", 32'(count_o), 32'd1);
         tick();
         checkOutput("lat_t2_opcode", 32'(fpu_opcode_o), 32'(vec[i].op));
         checkOutput("issue_op1", fpu_op1_o, vec[i].op1);
         waitRsp(base_rsp + 1, "vec_rsp_arrived");
         if (got_tag.size() > base_rsp) begin
            checkOutput("vec_tag", 32'(got_tag[base_rsp]), 32'(vec[i].tag));
            checkOutput("vec_result", got_res[base_rsp], vec[i].exp_res);
            checkOutput("vec_timeout", 32'(got_to[base_rsp]), 32'd0);
         end
         checkOutput("vec_one_issue", 32'(issue_cnt - base_iss), 32'd1);
         checkOutput("hold_opcode", 32'(fpu_opcode_o), 32'(FPU_IDLE));
         checkOutput("hold_op1", fpu_op1_o, vec[i].op1);
         checkOutput("hold_op2", 32'(fpu_op2_o), 32'(vec[i].op2));
         checkOutput("hold_rnd", 32'(fpu_rndMode_o), 32'(vec[i].rm));
         repeat (2) tick();
      end

      $display("[TB] fill with core not ready");
      core_ready = 1'b0;
      base_rsp   = got_tag.size();
      base_iss   = issue_cnt;
      for (int i = 0; i <= DEPTH; i++) begin
         req_valid_i   = 1'b1;
         req_opcode_i  = FPU_ADD;
         req_rndMode_i = FPU_RNDMODE_NEAREST;
         req_op1_i     = 32'(i * 16);
         req_op2_i     = 16'(i);
         req_tag_i     = 4'(i);
         #1;
         checkOutput("fill_ready", 32'(req_ready_o), 32'(i < DEPTH));
         tick();
      end
      req_valid_i = 1'b0;
      checkOutput("fill_count", 32'(count_o), 32'(DEPTH));
      checkOutput("fill_not_ready", 32'(req_ready_o), 32'd0);
      checkOutput("fill_no_issue", 32'(issue_cnt - base_iss), 32'd0);
      core_ready = 1'b1;
      waitRsp(base_rsp + DEPTH, "fill_rsp_arrived");
      repeat (20) tick();
      checkOutput("fill_rsp_total", 32'(got_tag.size() - base_rsp), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         if (got_tag.size() > base_rsp + i) begin
            checkOutput("fill_tag_order", 32'(got_tag[base_rsp + i]), 32'(i));
            checkOutput("fill_result", got_res[base_rsp + i], 32'(i * 17));
         end
      end
      checkOutput("fill_issues", 32'(issue_cnt - base_iss), 32'(DEPTH));
      checkOutput("fill_drained", 32'(count_o), 32'd0);

      $display("[TB] push/pop same cycle and response backpressure");
      rsp_ready_i = 1'b0;
      base_rsp    = got_tag.size();
      base_iss    = issue_cnt;
      applyStimulus(FPU_MUL, FPU_RNDMODE_NEAREST, 32'h0000_1000, 16'h0007, 4'd7);
      tick();
      checkOutput("pp_issue", 32'(fpu_opcode_o), 32'(FPU_MUL));
      checkOutput("pp_count_before", 32'(count_o), 32'd1);
      applyStimulus(FPU_SUB, FPU_RNDMODE_NEAREST, 32'h0000_2000, 16'h0008, 4'd8);
      checkOutput("pushpop_count", 32'(count_o), 32'd1);
      for (int k = 0; k < 50 && !rsp_valid_o; k++) tick();
      checkOutput("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      for (int k = 0; k < 10; k++) begin
         tick();
         checkOutput("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
         checkOutput("bp_hold_tag", 32'(rsp_tag_o), 32'd7);
         checkOutput("bp_hold_result", rsp_result_o, 32'h0000_1007);
         checkOutput("bp_no_second_issue", 32'(issue_cnt - base_iss), 32'd1);
      end
      rsp_ready_i = 1'b1;
      tick();
      checkOutput("bp_clear", 32'(rsp_valid_o), 32'd0);
      waitRsp(base_rsp + 2, "bp_rsp_arrived");
      if (got_tag.size() > base_rsp + 1) begin
         checkOutput("bp_first_tag", 32'(got_tag[base_rsp]), 32'd7);
         checkOutput("bp_second_tag", 32'(got_tag[base_rsp + 1]), 32'd8);
         checkOutput("bp_second_result", got_res[base_rsp + 1], 32'h0000_2008);
      end
      repeat (3) tick();

      $display("[TB] flush while waiting with three queued");
      core_ready = 1'b0;
      base_rsp   = got_tag.size();
      base_iss   = issue_cnt;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(FPU_ADD, FPU_RNDMODE_NEAREST, 32'(i + 100), 16'(i), 4'(i + 1));
      end
      core_hang  = 1'b1;
      core_ready = 1'b1;
      for (int k = 0; k < 20 && issue_cnt == base_iss; k++) tick();
      tick();
      checkOutput("fl_count_before", 32'(count_o), 32'd3);
      flush_i       = 1'b1;
      req_valid_i   = 1'b1;
      req_opcode_i  = FPU_DIV;
      req_op1_i     = 32'h0000_0BAD;
      req_op2_i     = 16'h0001;
      req_tag_i     = 4'hC;
      #1;
      checkOutput("fl_flush_out", 32'(fpu_flush_o), 32'd1);
      checkOutput("fl_ready_low", 32'(req_ready_o), 32'd0);
      tick();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      checkOutput("fl_count_after", 32'(count_o), 32'd0);
      checkOutput("fl_flush_off", 32'(fpu_flush_o), 32'd0);
      checkOutput("fl_opcode_idle", 32'(fpu_opcode_o), 32'(FPU_IDLE));
      core_hang = 1'b0;
      repeat (20) tick();
      checkOutput("fl_no_rsp", 32'(got_tag.size() - base_rsp), 32'd0);
      checkOutput("fl_issues", 32'(issue_cnt - base_iss), 32'd1);
      applyStimulus(FPU_SUB, FPU_RNDMODE_NEAREST, 32'h0000_0040, 16'h0002, 4'hA);
      tick();
      checkOutput("fl_idle_then_issue", 32'(fpu_opcode_o), 32'(FPU_SUB));
      waitRsp(base_rsp + 1, "fl_new_rsp_arrived");
      if (got_tag.size() > base_rsp) begin
         checkOutput("fl_new_tag", 32'(got_tag[base_rsp]), 32'hA);
         checkOutput("fl_new_result", got_res[base_rsp], 32'h0000_0042);
      end
      repeat (3) tick();

`ifdef LAMP_FPU_OPQ_TIMEOUT_EN
      $display("[TB] watchdog timeout");
      core_hang = 1'b1;
      base_rsp  = got_tag.size();
      applyStimulus(FPU_ADD, FPU_RNDMODE_NEAREST, 32'h0000_0005, 16'h0006, 4'd9);
      tick();
      checkOutput("to_issue", 32'(fpu_opcode_o), 32'(FPU_ADD));
      for (int w = 1; w <= TIMEOUT_CYC; w++) begin
         tick();
         checkOutput("to_flush_pulse", 32'(fpu_flush_o), 32'(w == TIMEOUT_CYC));
      end
      tick();
      checkOutput("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("to_rsp_flag", 32'(rsp_timeout_o), 32'd1);
      checkOutput("to_rsp_result", rsp_result_o, 32'd0);
      checkOutput("to_rsp_tag", 32'(rsp_tag_o), 32'd9);
      checkOutput("to_flush_done", 32'(fpu_flush_o), 32'd0);
      tick();
      checkOutput("to_rsp_cleared", 32'(rsp_timeout_o), 32'd0);
      core_hang = 1'b0;
      repeat (3) tick();
`else
      $display("[TB] core hang without watchdog");
      core_hang = 1'b1;
      base_rsp  = got_tag.size();
      applyStimulus(FPU_ADD, FPU_RNDMODE_NEAREST, 32'h0000_0005, 16'h0006, 4'd9);
      repeat (40) tick();
      checkOutput("hang_no_rsp", 32'(rsp_valid_o), 32'd0);
      checkOutput("hang_no_timeout", 32'(rsp_timeout_o), 32'd0);
      checkOutput("hang_no_flush", 32'(fpu_flush_o), 32'd0);
      flush_i = 1'b1;
      tick();
      flush_i   = 1'b0;
      core_hang = 1'b0;
      repeat (3) tick();
`endif

      $display("[TB] async reset during ISSUE");
      core_ready = 1'b0;
      base_rsp   = got_tag.size();
      applyStimulus(FPU_DIV, FPU_RNDMODE_TRUNCATE, 32'h0000_7777, 16'h1111, 4'd6);
      applyStimulus(FPU_MUL, FPU_RNDMODE_TRUNCATE, 32'h0000_5555, 16'h2222, 4'd2);
      core_ready = 1'b1;
      tick();
      checkOutput("ar_in_issue", 32'(fpu_opcode_o), 32'(FPU_DIV));
      base_iss = issue_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_opcode", 32'(fpu_opcode_o), 32'(FPU_IDLE));
      checkOutput("ar_count", 32'(count_o), 32'd0);
      checkOutput("ar_op1", fpu_op1_o, 32'd0);
      checkOutput("ar_op2", 32'(fpu_op2_o), 32'd0);
      checkOutput("ar_rnd", 32'(fpu_rndMode_o), 32'(FPU_RNDMODE_NEAREST));
      checkOutput("ar_ready", 32'(req_ready_o), 32'd1);
      checkOutput("ar_rsp_valid", 32'(rsp_valid_o), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      checkOutput("ar_no_rsp", 32'(got_tag.size() - base_rsp), 32'd0);
      checkOutput("ar_no_issue", 32'(issue_cnt - base_iss), 32'd0);
      checkOutput("ar_count_after", 32'(count_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
